// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, command table and state encodings for the UART command decoder.
package uart_cmd_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'h55;
   localparam logic [7:0] CMD_MODE  = 8'h01;
   localparam logic [7:0] CMD_WWL   = 8'h02;
   localparam logic [7:0] CMD_WBL   = 8'h03;
   localparam logic [7:0] CMD_RWL   = 8'h04;
   localparam logic [7:0] CMD_START = 8'h05;
   localparam logic [7:0] LEN_MODE  = 8'd1;
   localparam logic [7:0] LEN_WWL   = 8'd1;
   localparam logic [7:0] LEN_WBL   = 8'd9;
   localparam logic [7:0] LEN_RWL   = 8'd2;
   localparam logic [7:0] LEN_START = 8'd0;

   typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_CHK = 2'b01, ERR_CMD = 2'b10, ERR_TMO = 2'b11} err_e;
   typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_PAY, S_CHK, S_EXEC} state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   function automatic logic len_ok(input logic [7:0] cmd, input logic [7:0] len);
      return (cmd == CMD_MODE  && len == LEN_MODE)  ||
             (cmd == CMD_WWL   && len == LEN_WWL)   ||
             (cmd == CMD_WBL   && len == LEN_WBL)   ||
             (cmd == CMD_RWL   && len == LEN_RWL)   ||
             (cmd == CMD_START && len == LEN_START);
   endfunction
endpackage

// File: rtl/uart_recv.sv
// uart_recv: 8N1 byte receiver with 2-FF synchroniser, mid-bit sampling and glitch rejection on the start bit.
module uart_recv
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk_100m,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);
   localparam int CW = $clog2(BAUD_DIV);

   rx_state_e st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic valid_q, valid_d, ferr_q, ferr_d;
   // [1:0] synchronise the line, [2] is the previous synchronised sample for edge detection
   logic [2:0] sync_q;
   logic rxd, fell;

   assign rxd = sync_q[1];
   assign fell = sync_q[2] & ~sync_q[1];
   assign rx_byte = sh_q;
   assign rx_valid = valid_q;
   assign rx_ferr = ferr_q;

   always_comb begin
      st_d = st_q;
      cnt_d = cnt_q + 1'b1;
      bit_d = bit_q;
      sh_d = sh_q;
      valid_d = 1'b0;
      ferr_d = 1'b0;
      case (st_q)
         RX_IDLE: begin
            cnt_d = '0;
            st_d = fell ? RX_START : RX_IDLE;
         end
         RX_START: if (cnt_q == CW'(BAUD_DIV / 2 - 1)) begin
            cnt_d = '0;
            bit_d = '0;
            st_d = rxd ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt_q == CW'(BAUD_DIV - 1)) begin
            cnt_d = '0;
            sh_d = {rxd, sh_q[7:1]};
            bit_d = bit_q + 1'b1;
            st_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
         end
         default: if (cnt_q == CW'(BAUD_DIV - 1)) begin
            st_d = RX_IDLE;
            valid_d = rxd;
            ferr_d = ~rxd;
         end
      endcase
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b111;
         st_q <= RX_IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         valid_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], uart_rxd};
         st_q <= st_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         valid_q <= valid_d;
         ferr_q <= ferr_d;
      end
   end
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses checksummed 0x55 command frames from the host UART and drives
// the DRAM core configuration, WBL/RWL write strobes and the IO_EN start pulse.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD        = 115200,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk_100m,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic [1:0]  cfg_io_model,
   output logic [1:0]  cfg_cim_model,
   output logic        cfg_demux_add_3,
   output logic [5:0]  cfg_wwl_add,
   output logic        wbl_we,
   output logic [3:0]  wbl_core,
   output logic [63:0] wbl_data,
   output logic        rwl_we,
   output logic [3:0]  rwl_core,
   output logic [5:0]  rwl_add,
   output logic [1:0]  demux_add,
   output logic        io_en,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [1:0]  err_code
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [7:0] rx_byte;
   logic rx_valid, rx_ferr;

   uart_recv #(.BAUD_DIV(CLK_FREQ / BAUD)) u_recv (
      .clk_100m(clk_100m),
      .rst_n(rst_n),
      .uart_rxd(uart_rxd),
      .rx_byte(rx_byte),
      .rx_valid(rx_valid),
      .rx_ferr(rx_ferr)
   );

   state_e st_q, st_d;
   err_e err_q, err_d;
   logic [7:0] cmd_q, cmd_d, cnt_q, cnt_d, chk_q, chk_d;
   logic bad_q, bad_d;
   logic [71:0] buf_q, buf_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [1:0] io_q, io_d, cim_q, cim_d, dm_q, dm_d;
   logic d3_q, d3_d;
   logic [5:0] wwl_q, wwl_d, ra_q, ra_d;
   logic [3:0] wc_q, wc_d, rc_q, rc_d;
   logic [63:0] wd_q, wd_d;
   logic wbl_we_q, wbl_we_d, rwl_we_q, rwl_we_d, io_en_q, io_en_d, ok_q, ok_d, fe_q, fe_d;
   logic core_bad, abort;

   // the core index is the first payload byte, which sits at a different buffer offset per command
   assign core_bad = (cmd_q == CMD_WBL && buf_q[71:68] != 4'd0) || (cmd_q == CMD_RWL && buf_q[15:12] != 4'd0);
   assign abort = st_q != S_SYNC && st_q != S_EXEC && (rx_ferr || idle_q == TW'(TIMEOUT_CYC - 1));

   assign cfg_io_model = io_q;
   assign cfg_cim_model = cim_q;
   assign cfg_demux_add_3 = d3_q;
   assign cfg_wwl_add = wwl_q;
   assign wbl_we = wbl_we_q;
   assign wbl_core = wc_q;
   assign wbl_data = wd_q;
   assign rwl_we = rwl_we_q;
   assign rwl_core = rc_q;
   assign rwl_add = ra_q;
   assign demux_add = dm_q;
   assign io_en = io_en_q;
   assign frame_ok = ok_q;
   assign frame_err = fe_q;
   assign err_code = err_q;

   always_comb begin
      st_d = st_q;
      err_d = err_q;
      cmd_d = cmd_q;
      cnt_d = cnt_q;
      chk_d = chk_q;
      bad_d = bad_q;
      buf_d = buf_q;
      idle_d = (st_q == S_SYNC || rx_valid) ? '0 : idle_q + 1'b1;
      io_d = io_q;
      cim_d = cim_q;
      d3_d = d3_q;
      wwl_d = wwl_q;
      wc_d = wc_q;
      wd_d = wd_q;
      rc_d = rc_q;
      ra_d = ra_q;
      dm_d = dm_q;
      wbl_we_d = 1'b0;
      rwl_we_d = 1'b0;
      io_en_d = 1'b0;
      ok_d = 1'b0;
      fe_d = 1'b0;
      if (abort) begin
         st_d = S_SYNC;
         fe_d = 1'b1;
         err_d = ERR_TMO;
      end else begin
         case (st_q)
            S_SYNC: st_d = (rx_valid && rx_byte == SYNC_BYTE) ? S_CMD : S_SYNC;
            S_CMD: if (rx_valid) begin
               cmd_d = rx_byte;
               st_d = S_LEN;
            end
            S_LEN: if (rx_valid) begin
               bad_d = ~len_ok(cmd_q, rx_byte);
               cnt_d = rx_byte;
               chk_d = cmd_q ^ rx_byte;
               st_d = (rx_byte == 8'd0) ? S_CHK : S_PAY;
            end
            S_PAY: if (rx_valid) begin
               buf_d = {buf_q[63:0], rx_byte};
               chk_d = chk_q ^ rx_byte;
               cnt_d = cnt_q - 1'b1;
               st_d = (cnt_q == 8'd1) ? S_CHK : S_PAY;
            end
            S_CHK: if (rx_valid) begin
               if (bad_q || rx_byte != chk_q || core_bad) begin
                  st_d = S_SYNC;
                  fe_d = 1'b1;
                  err_d = (bad_q || rx_byte == chk_q) ? ERR_CMD : ERR_CHK;
               end else begin
                  st_d = S_EXEC;
                  ok_d = 1'b1;
                  case (cmd_q)
                     CMD_MODE: begin
                        io_d = buf_q[1:0];
                        cim_d = buf_q[3:2];
                        d3_d = buf_q[4];
                     end
                     CMD_WWL: wwl_d = buf_q[5:0];
                     CMD_WBL: begin
                        wbl_we_d = 1'b1;
                        wc_d = buf_q[67:64];
                        wd_d = buf_q[63:0];
                     end
                     CMD_RWL: begin
                        rwl_we_d = 1'b1;
                        rc_d = buf_q[11:8];
                        ra_d = buf_q[5:0];
                        dm_d = buf_q[7:6];
                     end
                     default: io_en_d = 1'b1;
                  endcase
               end
            end
            default: st_d = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= S_SYNC;
         err_q <= ERR_NONE;
         cmd_q <= '0;
         cnt_q <= '0;
         chk_q <= '0;
         bad_q <= 1'b0;
         buf_q <= '0;
         idle_q <= '0;
         io_q <= 2'b00;
         cim_q <= 2'b10;
         d3_q <= 1'b0;
         wwl_q <= '0;
         wc_q <= '0;
         wd_q <= '0;
         rc_q <= '0;
         ra_q <= '0;
         dm_q <= '0;
         wbl_we_q <= 1'b0;
         rwl_we_q <= 1'b0;
         io_en_q <= 1'b0;
         ok_q <= 1'b0;
         fe_q <= 1'b0;
      end else begin
         st_q <= st_d;
         err_q <= err_d;
         cmd_q <= cmd_d;
         cnt_q <= cnt_d;
         chk_q <= chk_d;
         bad_q <= bad_d;
         buf_q <= buf_d;
         idle_q <= idle_d;
         io_q <= io_d;
         cim_q <= cim_d;
         d3_q <= d3_d;
         wwl_q <= wwl_d;
         wc_q <= wc_d;
         wd_q <= wd_d;
         rc_q <= rc_d;
         ra_q <= ra_d;
         dm_q <= dm_d;
         wbl_we_q <= wbl_we_d;
         rwl_we_q <= rwl_we_d;
         io_en_q <= io_en_d;
         ok_q <= ok_d;
         fe_q <= fe_d;
      end
   end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: serial frames into the decoder, checked every cycle against a frame-level model.
module tb_uart_cmd_decoder;
   localparam int CLK_FREQ = 800_000;
   localparam int BAUD = 100_000;
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int TMO = 400;

   logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
   logic [1:0] cfg_io_model, cfg_cim_model, demux_add, err_code;
   logic cfg_demux_add_3, wbl_we, rwl_we, io_en, frame_ok, frame_err;
   logic [5:0] cfg_wwl_add, rwl_add;
   logic [3:0] wbl_core, rwl_core;
   logic [63:0] wbl_data;

   uart_cmd_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
      .clk_100m(clk), .rst_n(rst_n), .uart_rxd(rxd),
      .cfg_io_model(cfg_io_model), .cfg_cim_model(cfg_cim_model),
      .cfg_demux_add_3(cfg_demux_add_3), .cfg_wwl_add(cfg_wwl_add),
      .wbl_we(wbl_we), .wbl_core(wbl_core), .wbl_data(wbl_data),
      .rwl_we(rwl_we), .rwl_core(rwl_core), .rwl_add(rwl_add), .demux_add(demux_add),
      .io_en(io_en), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic ok;
      logic [1:0] code;
      logic [7:0] cmd;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [63:0] data;
   } ev_t;

   ev_t q[$];
   logic [7:0] pay[16];
   logic [1:0] m_io, m_cim, m_dm, m_err;
   logic m_d3;
   logic [5:0] m_wwl, m_ra;
   logic [3:0] m_wc, m_rc;
   logic [63:0] m_wd;
   int n_chk = 0, n_fail = 0, n_io = 0, n_ok = 0;

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int req_len(input logic [7:0] c);
      return (c == 8'd1 || c == 8'd2) ? 1 : c == 8'd3 ? 9 : c == 8'd4 ? 2 : c == 8'd5 ? 0 : -1;
   endfunction

   task automatic mreset();
      m_io = 2'b00; m_cim = 2'b10; m_d3 = 1'b0; m_wwl = '0;
      m_wc = '0; m_wd = '0; m_rc = '0; m_ra = '0; m_dm = '0; m_err = 2'b00;
      q.delete();
   endtask

   // per-cycle check: pulses must match the next expected frame outcome, data outputs must match the model
   always @(negedge clk) begin : cmp
      ev_t e;
      logic [4:0] got, want;
      if (rst_n) begin
         got = {frame_ok, frame_err, wbl_we, rwl_we, io_en};
         if (io_en) n_io++;
         if (frame_ok) n_ok++;
         if (got != 5'd0) begin
            if (q.size() == 0) check("unexpected_pulse", 96'(got), 96'd0);
            else begin
               e = q.pop_front();
               want = {e.ok, ~e.ok, e.ok && e.cmd == 8'd3, e.ok && e.cmd == 8'd4, e.ok && e.cmd == 8'd5};
               if (!e.ok) m_err = e.code;
               else case (e.cmd)
                  8'd1: begin m_io = e.p0[1:0]; m_cim = e.p0[3:2]; m_d3 = e.p0[4]; end
                  8'd2: m_wwl = e.p0[5:0];
                  8'd3: begin m_wc = e.p0[3:0]; m_wd = e.data; end
                  8'd4: begin m_rc = e.p0[3:0]; m_ra = e.p1[5:0]; m_dm = e.p1[7:6]; end
                  default: ;
               endcase
               check("pulses", 96'(got), 96'(want));
            end
         end
         check("outputs",
            96'({cfg_io_model, cfg_cim_model, cfg_demux_add_3, cfg_wwl_add, wbl_core, wbl_data, rwl_core, rwl_add, demux_add, err_code}),
            96'({m_io, m_cim, m_d3, m_wwl, m_wc, m_wd, m_rc, m_ra, m_dm, m_err}));
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
      rxd = stop;
      repeat (DIV) @(negedge clk);
      rxd = 1'b1;
      repeat ($urandom_range(2, 12)) @(negedge clk);
   endtask

   task automatic wait_drain(input int lim);
      int n = 0;
      while (q.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("frame_outcome_seen", 96'(q.size()), 96'd0);
      q.delete();
   endtask

   // expected outcome follows from the frame content alone: framing, then table, then checksum, then core index
   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] flip, input int ferr_at);
      logic [7:0] x, b;
      ev_t e;
      int n;
      x = cmd ^ len;
      for (int i = 0; i < int'(len); i++) x ^= pay[i];
      e = '0;
      e.cmd = cmd; e.p0 = pay[0]; e.p1 = pay[1];
      e.data = {pay[1], pay[2], pay[3], pay[4], pay[5], pay[6], pay[7], pay[8]};
      if (ferr_at > 0) e.code = 2'b11;
      else if (req_len(cmd) != int'(len)) e.code = 2'b10;
      else if (flip != 8'd0) e.code = 2'b01;
      else if ((cmd == 8'd3 || cmd == 8'd4) && pay[0] > 8'h0F) e.code = 2'b10;
      else e.ok = 1'b1;
      q.push_back(e);
      n = int'(len) + 4;
      for (int i = 0; i < n; i++) begin
         b = (i == 0) ? 8'h55 : (i == 1) ? cmd : (i == 2) ? len : (i == n - 1) ? (x ^ flip) : pay[i - 3];
         send_byte(b, logic'(i != ferr_at));
         if (i == ferr_at) break;
      end
      wait_drain(4 * DIV);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] cmd, len, flip;
      int kind, fa, io0;
      mreset();
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("reset_cim", 96'(cfg_cim_model), 96'd2);
      check("reset_io", 96'(cfg_io_model), 96'd0);
      check("reset_err", 96'(err_code), 96'd0);
      check("reset_pulses", 96'({frame_ok, frame_err, wbl_we, rwl_we, io_en}), 96'd0);

      pay[0] = 8'h05;
      send_frame(8'h01, 8'd1, 8'h00, -1);
      check("f1_io", 96'(cfg_io_model), 96'd1);
      check("f1_cim", 96'(cfg_cim_model), 96'd1);
      check("f1_ok_count", 96'(n_ok), 96'd1);

      pay[0] = 8'h07; pay[1] = 8'h01; pay[2] = 8'h23; pay[3] = 8'h45; pay[4] = 8'h67;
      pay[5] = 8'h89; pay[6] = 8'hAB; pay[7] = 8'hCD; pay[8] = 8'hEF;
      send_frame(8'h03, 8'd9, 8'h00, -1);
      check("f2_wbl_core", 96'(wbl_core), 96'd7);
      check("f2_wbl_data", 96'(wbl_data), 96'h0123456789ABCDEF);

      pay[0] = 8'h0F; pay[1] = 8'hC5;
      send_frame(8'h04, 8'd2, 8'h00, -1);
      send_frame(8'h05, 8'd0, 8'h00, -1);
      check("f3_rwl_core", 96'(rwl_core), 96'hF);
      check("f3_rwl_add", 96'(rwl_add), 96'h05);
      check("f3_demux", 96'(demux_add), 96'd3);
      check("f4_io_en_count", 96'(n_io), 96'd1);

      pay[0] = 8'h2A;
      send_frame(8'h02, 8'd1, 8'h3C, -1);
      check("bad_chk_code", 96'(err_code), 96'd1);
      check("bad_chk_wwl", 96'(cfg_wwl_add), 96'd0);
      send_frame(8'h02, 8'd3, 8'h00, -1);
      check("bad_len_code", 96'(err_code), 96'd2);
      pay[0] = 8'h10;
      send_frame(8'h03, 8'd9, 8'h00, -1);
      check("bad_core_code", 96'(err_code), 96'd2);
      check("bad_core_data", 96'(wbl_data), 96'h0123456789ABCDEF);

      pay[0] = 8'h03;
      send_frame(8'h01, 8'd1, 8'h00, 3);
      check("ferr_code", 96'(err_code), 96'd3);
      check("ferr_io", 96'(cfg_io_model), 96'd1);

      pay[0] = 8'h09;
      send_frame(8'h02, 8'd1, 8'h00, -1);
      send_frame(8'h03, 8'd9, 8'h00, -1);
      check("err_held", 96'(err_code), 96'd3);

      q.push_back(ev_t'({1'b0, 2'b11, 8'h01, 80'd0}));
      send_byte(8'h55, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_drain(TMO + 4 * DIV);
      check("timeout_code", 96'(err_code), 96'd3);
      pay[0] = 8'h2A;
      send_frame(8'h02, 8'd1, 8'h00, -1);
      check("after_timeout_wwl", 96'(cfg_wwl_add), 96'h2A);

      pay[0] = 8'h07; pay[1] = 8'h11;
      send_byte(8'h55, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h09, 1'b1);
      send_byte(8'h07, 1'b1);
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      mreset();
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("midreset_cim", 96'(cfg_cim_model), 96'd2);
      check("midreset_wbl", 96'(wbl_data), 96'd0);

      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            cmd = 8'($urandom);
            if (cmd == 8'h55) cmd = 8'h54;
            send_byte(cmd, logic'($urandom_range(0, 1)));
         end
         kind = $urandom_range(0, 8);
         cmd = 8'($urandom_range(1, 5));
         flip = 8'h00;
         fa = -1;
         if (kind <= 4) cmd = 8'(kind + 1);
         if (kind == 5) flip = 8'($urandom_range(1, 255));
         if (kind == 7) begin
            cmd = 8'($urandom_range(3, 4));
            pay[0] = 8'($urandom_range(16, 255));
         end else pay[0] = {4'h0, pay[0][3:0]};
         len = 8'(req_len(cmd));
         if (kind == 6) begin
            cmd = 8'($urandom_range(1, 12));
            len = 8'($urandom_range(0, 12));
            if (req_len(cmd) == int'(len)) len = len + 8'd1;
         end
         if (kind == 8) fa = $urandom_range(1, int'(len) + 3);
         io0 = n_io;
         send_frame(cmd, len, flip, fa);
      end
      check("random_io_bound", 96'(n_io >= io0), 96'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
